// File: rtl/mmio_port_bank.sv
// rtl/mmio_port_bank.sv - memory-mapped bank of output registers, synchronized input ports and a change-status register
module mmio_port_bank #(
   parameter int               WIDTH         = 32,
   parameter int               N_OUT         = 4,
   parameter int               N_IN          = 4,
   parameter logic [WIDTH-1:0] BASE_ADDR     = 32'h40000000,
   parameter int               IN_OFFSET     = 16,
   parameter int               STATUS_OFFSET = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_addr,
   input  logic [2:0]             wr_size,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   input  logic [WIDTH-1:0]       rd_addr,
   input  logic [2:0]             rd_size,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   rd_valid,
   input  logic [N_IN*WIDTH-1:0]  port_in,
   output logic [N_OUT*WIDTH-1:0] port_out,
   output logic [N_OUT-1:0]       wr_pulse
);

   // Lane mask for an access size: byte, half-word, or the full word.
   function automatic logic [WIDTH-1:0] size_mask(input logic [1:0] sz);
      logic [WIDTH-1:0] m;
      case (sz)
         2'd0:    m = WIDTH'(8'hFF);
         2'd1:    m = WIDTH'(16'hFFFF);
         default: m = '1;
      endcase
      return m;
   endfunction

   // Right-aligned extraction of a byte or half-word, sign- or zero-extended.
   function automatic logic [WIDTH-1:0] extract(input logic [WIDTH-1:0] v, input logic [2:0] sz);
      logic [WIDTH-1:0] r;
      case (sz[1:0])
         2'd0:    r = sz[2] ? {{(WIDTH-8){1'b0}}, v[7:0]}   : {{(WIDTH-8){v[7]}}, v[7:0]};
         2'd1:    r = sz[2] ? {{(WIDTH-16){1'b0}}, v[15:0]} : {{(WIDTH-16){v[15]}}, v[15:0]};
         default: r = v;
      endcase
      return r;
   endfunction

   logic [WIDTH-1:0] out_q  [N_OUT];
   logic [WIDTH-1:0] sync1  [N_IN];
   logic [WIDTH-1:0] sync2  [N_IN];
   logic [WIDTH-1:0] prev   [N_IN];
   logic [N_IN-1:0]  flags;
   logic [N_IN-1:0]  chg;
   logic [1:0]       prime_cnt;

   logic [WIDTH-1:0] wr_off;
   logic [WIDTH-1:0] rd_off;
   logic [WIDTH-1:0] wr_mask;
   logic [N_OUT-1:0] wr_sel;
   logic             rd_hit;
   logic             rd_is_status;
   logic [WIDTH-1:0] rd_word;
   logic             status_rd;
   logic             unused_wr_size;

   // Size bit 2 only selects extension on reads; writes never look at it.
   assign unused_wr_size = wr_size[2];

   assign wr_off    = wr_addr - BASE_ADDR;
   assign rd_off    = rd_addr - BASE_ADDR;
   assign wr_mask   = size_mask(wr_size[1:0]);
   assign status_rd = rd_en && rd_is_status;

   for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
      assign port_out[gi*WIDTH +: WIDTH] = out_q[gi];
   end

   // Decode which output register (if any) the current write targets.
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (wr_en && (wr_off == WIDTH'(i))) begin
            wr_sel[i] = 1'b1;
         end
      end
   end

   // Read mux: out registers, synchronized inputs and the status word.
   always_comb begin
      rd_hit       = 1'b0;
      rd_is_status = 1'b0;
      rd_word      = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (rd_off == WIDTH'(i)) begin
            rd_hit  = 1'b1;
            rd_word = out_q[i];
         end
      end
      for (int j = 0; j < N_IN; j++) begin
         if (rd_off == WIDTH'(IN_OFFSET + j)) begin
            rd_hit  = 1'b1;
            rd_word = sync2[j];
         end
      end
      if (rd_off == WIDTH'(STATUS_OFFSET)) begin
         rd_hit       = 1'b1;
         rd_is_status = 1'b1;
         rd_word      = WIDTH'(flags);
      end
   end

   // A change only counts once the synchronizer pipeline holds real samples.
   always_comb begin
      chg = '0;
      for (int j = 0; j < N_IN; j++) begin
         chg[j] = (prime_cnt == 2'd3) && (sync2[j] != prev[j]);
      end
   end

   // Output registers: lane-masked update and a one-cycle strobe per write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < N_OUT; i++) begin
            out_q[i] <= '0;
         end
         wr_pulse <= '0;
      end else begin
         for (int i = 0; i < N_OUT; i++) begin
            if (wr_sel[i]) begin
               out_q[i] <= (out_q[i] & ~wr_mask) | (wr_data & wr_mask);
            end
         end
         wr_pulse <= wr_sel;
      end
   end

   // Registered read response; the mux sees pre-write register contents.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en && rd_hit;
         rd_data  <= (rd_en && rd_hit) ? extract(rd_word, rd_size) : '0;
      end
   end

   // Input synchronizers, history register, priming counter and change flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int j = 0; j < N_IN; j++) begin
            sync1[j] <= '0;
            sync2[j] <= '0;
            prev[j]  <= '0;
         end
         prime_cnt <= 2'd0;
         flags     <= '0;
      end else begin
         for (int j = 0; j < N_IN; j++) begin
            sync1[j] <= port_in[j*WIDTH +: WIDTH];
            sync2[j] <= sync1[j];
            prev[j]  <= sync2[j];
         end
         prime_cnt <= (prime_cnt == 2'd3) ? 2'd3 : prime_cnt + 2'd1;
         // A read returns every flag, so it clears them all; a new change still lands.
         flags     <= status_rd ? chg : (flags | chg);
      end
   end

endmodule

// File: tb/tb_mmio_port_bank.sv
// tb/tb_mmio_port_bank.sv - scoreboard bench for mmio_port_bank with a queue-based reference model
module tb_mmio_port_bank;

   localparam logic [31:0] BASE = 32'h40000000;

   logic         clk = 1'b0;
   logic         reset;
   logic         wr_en;
   logic [31:0]  wr_addr;
   logic [2:0]   wr_size;
   logic [31:0]  wr_data;
   logic         rd_en;
   logic [31:0]  rd_addr;
   logic [2:0]   rd_size;
   logic [31:0]  rd_data;
   logic         rd_valid;
   logic [127:0] port_in;
   logic [127:0] port_out;
   logic [3:0]   wr_pulse;

   mmio_port_bank dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_size  (wr_size),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_size  (rd_size),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .port_in  (port_in),
      .port_out (port_out),
      .wr_pulse (wr_pulse)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic        v;
      logic [31:0] d;
   } rd_exp_t;

   typedef struct {
      int           due;
      logic [3:0]   p;
      logic [127:0] po;
   } wr_exp_t;

   rd_exp_t rq[$];
   wr_exp_t wq[$];

   logic [31:0] m_out [4];
   logic [31:0] m_in  [4];
   logic [3:0]  m_flags;
   int          since_rst;
   bit          done = 1'b0;

   int checks   = 0;
   int failures = 0;

   function automatic logic [31:0] ext(input logic [31:0] v, input logic [2:0] sz);
      logic [31:0] r;
      if (sz[1:0] == 2'd0) begin
         r = v & 32'hFF;
         if (!sz[2] && r >= 32'h80) r = r | 32'hFFFFFF00;
      end else if (sz[1:0] == 2'd1) begin
         r = v & 32'hFFFF;
         if (!sz[2] && r >= 32'h8000) r = r | 32'hFFFF0000;
      end else begin
         r = v;
      end
      return r;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [2:0] sz);
      if (sz[1:0] == 2'd0) return (old & 32'hFFFFFF00) | (wd & 32'h000000FF);
      if (sz[1:0] == 2'd1) return (old & 32'hFFFF0000) | (wd & 32'h0000FFFF);
      return wd;
   endfunction

   function automatic logic [127:0] pack_out();
      logic [127:0] p;
      for (int i = 0; i < 4; i++) p[i*32 +: 32] = m_out[i];
      return p;
   endfunction

   task automatic step(input logic rst, input logic we, input logic [31:0] wa, input logic [2:0] ws,
                       input logic [31:0] wd, input logic re, input logic [31:0] ra, input logic [2:0] rs);
      rd_exp_t     re_e;
      wr_exp_t     we_e;
      logic [31:0] off;
      reset   = rst;
      wr_en   = we;
      wr_addr = wa;
      wr_size = ws;
      wr_data = wd;
      rd_en   = re;
      rd_addr = ra;
      rd_size = rs;
      if (!rst) begin
         for (int i = 0; i < 4; i++) m_out[i] = '0;
         m_flags   = '0;
         since_rst = 0;
         we_e.due = cyc + 1; we_e.p = '0; we_e.po = '0;
         wq.push_back(we_e);
         if (re) begin
            re_e.due = cyc + 1; re_e.v = 1'b0; re_e.d = '0;
            rq.push_back(re_e);
         end
      end else begin
         if (re) begin
            off = ra - BASE;
            re_e.due = cyc + 1; re_e.v = 1'b1; re_e.d = '0;
            if (off < 4) re_e.d = ext(m_out[off], rs);
            else if (off >= 16 && off < 20) re_e.d = ext(m_in[off-16], rs);
            else if (off == 32) begin
               re_e.d  = {28'b0, m_flags};
               m_flags = '0;
            end else re_e.v = 1'b0;
            rq.push_back(re_e);
         end
         if (we) begin
            off = wa - BASE;
            we_e.due = cyc + 1; we_e.p = '0;
            if (off < 4) begin
               m_out[off] = merge(m_out[off], wd, ws);
               we_e.p[off] = 1'b1;
            end
            we_e.po = pack_out();
            wq.push_back(we_e);
         end
         since_rst++;
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [2:0] sz);
      step(1'b1, 1'b0, '0, '0, '0, 1'b1, a, sz);
   endtask

   task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
      step(1'b1, 1'b1, a, sz, d, 1'b0, '0, '0);
   endtask

   task automatic set_in(input int j, input logic [31:0] v);
      port_in[j*32 +: 32] = v;
      if (since_rst >= 5 && v != m_in[j]) m_flags[j] = 1'b1;
      m_in[j] = v;
   endtask

   function automatic logic [31:0] pick_addr(output bit is_reg);
      int r;
      r = $urandom_range(0, 9);
      is_reg = 1'b0;
      if (r <= 3) begin is_reg = 1'b1; return BASE + $urandom_range(0, 3); end
      if (r <= 5) return BASE + 16 + $urandom_range(0, 3);
      if (r == 6) begin is_reg = 1'b1; return BASE + 32; end
      if (r == 7) return BASE + 4 + $urandom_range(0, 11);
      if (r == 8) return BASE + 20 + $urandom_range(0, 11);
      return $urandom();
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pop expected responses as they fall due and compare.
   initial begin
      rd_exp_t re_e;
      wr_exp_t we_e;
      forever begin
         @(negedge clk);
         while (rq.size() > 0 && rq[0].due < cyc) begin
            chk("rd_missed_due", 128'(rq[0].due), 128'(cyc));
            void'(rq.pop_front());
         end
         while (wq.size() > 0 && wq[0].due < cyc) begin
            chk("wr_missed_due", 128'(wq[0].due), 128'(cyc));
            void'(wq.pop_front());
         end
         if (rq.size() > 0 && rq[0].due == cyc) begin
            re_e = rq.pop_front();
            chk("rd_valid", 128'(rd_valid), 128'(re_e.v));
            chk("rd_data", 128'(rd_data), 128'(re_e.d));
         end else begin
            chk("rd_valid_idle", 128'(rd_valid), 128'(0));
         end
         if (wq.size() > 0 && wq[0].due == cyc) begin
            we_e = wq.pop_front();
            chk("wr_pulse", 128'(wr_pulse), 128'(we_e.p));
            chk("port_out", port_out, we_e.po);
         end else begin
            chk("wr_pulse_idle", 128'(wr_pulse), 128'(0));
         end
         if (done) begin
            chk("queues_drained", 128'(rq.size() + wq.size()), 128'(0));
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // Stimulus: directed scenarios, then randomized rounds.
   initial begin
      bit          is_reg;
      logic [31:0] a;
      logic [31:0] nv;
      logic [2:0]  rs;
      port_in = '0;
      for (int j = 0; j < 4; j++) m_in[j] = '0;
      set_in(1, 32'h00000080);
      set_in(2, 32'h12345678);
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, BASE + 16, 3'd2);
      step(1'b0, 1'b1, BASE + 1, 3'd2, 32'hFFFFFFFF, 1'b1, BASE, 3'd2);
      idle(6);

      rd(BASE + 32'h11, 3'd0);
      rd(BASE + 32, 3'd2);

      wr(BASE + 2, 3'd2, 32'hDEADBEEF);
      idle(1);
      wr(BASE + 2, 3'd0, 32'h00000011);
      rd(BASE + 2, 3'd2);

      set_in(3, 32'h5);
      idle(4);
      rd(BASE + 32, 3'd2);
      rd(BASE + 32, 3'd2);

      nv = m_in[0] ^ 32'h0000_0001;
      port_in[31:0] = nv;
      idle(2);
      rd(BASE + 32, 3'd2);
      m_flags[0] = 1'b1;
      m_in[0]    = nv;
      idle(2);
      rd(BASE + 32, 3'd2);

      wr(BASE + 1, 3'd2, 32'h55AA55AA);
      step(1'b0, 1'b1, BASE + 1, 3'd2, 32'hCAFEF00D, 1'b1, BASE + 1, 3'd2);
      idle(1);
      rd(BASE + 32'h100, 3'd2);
      idle(6);

      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(0, 3) == 0) set_in($urandom_range(0, 3), m_in[$urandom_range(0, 3)]);
         else set_in($urandom_range(0, 3), $urandom());
         idle(4);
         for (int s = 0; s < 8; s++) begin
            a  = pick_addr(is_reg);
            rs = is_reg ? {1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1))} : 3'($urandom_range(0, 7));
            step(1'b1, 1'($urandom_range(0, 1)), pick_addr(is_reg), 3'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 1)), a, rs);
         end
      end
      idle(3);
      done = 1'b1;
   end

endmodule

// File: doc/mmio_port_bank.md
MMIO_PORT_BANK -- requirements
Module: mmio_port_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every port and bus.
REQ-002 SHALL have parameter N_OUT, default 4, range 1..32, output port count.
REQ-003 SHALL have parameter N_IN, default 4, range 1..32, input port count.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h40000000, word-indexed base address.
REQ-005 SHALL have parameter IN_OFFSET, default 16, offset of input port 0 from BASE_ADDR.
REQ-006 SHALL have parameter STATUS_OFFSET, default 32, offset of the change-status register.
REQ-007 Ports: clk  input  1  sole clock, all logic on rising edge.
REQ-008 Ports: reset  input  1  synchronous, active-low reset (reset==0 resets on the next rising clk edge).
REQ-009 Ports: wr_en  input  1  write request, one transfer per cycle.
REQ-010 Ports: wr_addr  input  WIDTH  word-indexed write address.
REQ-011 Ports: wr_size  input  3  access size: [1:0]=0 byte, 1 half, 2/3 word; [2] ignored for writes.
REQ-012 Ports: wr_data  input  WIDTH  write data, right-aligned.
REQ-013 Ports: rd_en  input  1  read request.
REQ-014 Ports: rd_addr  input  WIDTH  word-indexed read address.
REQ-015 Ports: rd_size  input  3  [1:0] as wr_size; [2]=0 sign-extend, 1 zero-extend.
REQ-016 Ports: rd_data  output  WIDTH  registered read data.
REQ-017 Ports: rd_valid  output  1  registered; high one cycle when rd_data holds a mapped read result.
REQ-018 Ports: port_in  input  N_IN*WIDTH  asynchronous input ports, port j at bits [j*WIDTH +: WIDTH].
REQ-019 Ports: port_out  output  N_OUT*WIDTH  registered output ports, port i at bits [i*WIDTH +: WIDTH].
REQ-020 Ports: wr_pulse  output  N_OUT  registered one-cycle strobe per output port written.

Function
REQ-021 Address map SHALL be: out port i at BASE_ADDR+i; in port j at BASE_ADDR+IN_OFFSET+j; status at BASE_ADDR+STATUS_OFFSET; all else unmapped.
REQ-022 Write to out port i SHALL update only the lanes selected by wr_size (byte [7:0], half [15:0], word all); other bits SHALL hold.
REQ-023 Write to out port i SHALL assert wr_pulse[i] the cycle after the write edge, for exactly one cycle.
REQ-024 Writes to in-port, status or unmapped addresses SHALL be ignored with no side effect.
REQ-025 Each port_in word SHALL pass a 2-flop synchronizer; a third register SHALL hold the previous synchronized value.
REQ-026 Change flag j SHALL set when synchronized value != previous value, once priming is complete.
REQ-027 Priming: a 2-bit counter SHALL count from 0 to 3 after reset release and saturate; flags SHALL NOT set before it reaches 3.
REQ-028 Read latency SHALL be 1 cycle: request on edge N -> rd_data/rd_valid valid after edge N+1, for one cycle.
REQ-029 Out-port read SHALL return the register value before any same-cycle write (read-before-write).
REQ-030 In-port read SHALL return the synchronized value, size-extracted and sign/zero-extended per rd_size.
REQ-031 Status read SHALL return flags in bits [N_IN-1:0], zeros above, and SHALL clear the flags returned.
REQ-032 Flag set and status read-clear in the same cycle SHALL leave that flag set.
REQ-033 Unmapped read SHALL drive rd_valid=0 and rd_data=0 on the next cycle.
REQ-034 wr_en and rd_en SHALL be serviced independently in the same cycle.

Reset
REQ-035 reset==0 SHALL clear port_out, wr_pulse, rd_data, rd_valid, synchronizers, previous values, flags and the priming counter to 0.
REQ-036 Reset asserted mid-operation SHALL override any same-cycle write or read; no wr_pulse or rd_valid SHALL follow.

Verification
REQ-037 Word write 32'hDEADBEEF to 32'h40000002 -> port_out[2]=32'hDEADBEEF, wr_pulse=4'b0100 for one cycle.
REQ-038 Then byte write 32'h00000011 to same address -> port_out[2]=32'hDEADBE11; other ports unchanged.
REQ-039 port_in[1]=32'h00000080 stable from reset release; read 32'h40000011 size=0 sign -> rd_data=32'hFFFFFF80, rd_valid=1; status read -> 0 (priming suppressed).
REQ-040 port_in[3] changes 0->5 after priming; status read -> 32'h8; second read -> 0.
REQ-041 Change of port_in[0] landing on status read-clear cycle -> first read excludes bit 0, next read returns 32'h1.
REQ-042 Write to 32'h40000001 with reset==0 same cycle -> port_out[1]=0, wr_pulse=0; read of 32'h40000100 -> rd_valid=0, rd_data=0.
